// File: rtl/tensor_core_engine.sv
// DIMxDIM signed matrix engine: matmul, add, relu and matmul-accumulate with saturation.
// Operands are captured at start and BATCH_SIZE result elements are written per RUN cycle.
module tensor_core_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int BATCH_SIZE = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(DIM)+1
) (
  input  logic                                  clock_in,
  input  logic                                  reset_n_in,
  input  logic                                  start_in,
  input  logic                                  abort_in,
  input  logic [1:0]                            operation_select_in,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
  output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] tensor_core_output,
  output logic                                  busy_out,
  output logic                                  done_out,
  output logic                                  overflow_out
);

  localparam int NELEM = DIM*DIM;
  localparam int CNT_W = $clog2(NELEM)+1;
  localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MATMUL = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_RELU   = 2'b10;
  localparam logic [1:0] OP_MAC    = 2'b11;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if ((NELEM % BATCH_SIZE) != 0) begin : g_bad_batch
    $error("BATCH_SIZE must divide DIM*DIM");
  end

  logic [1:0]                            state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [1:0]                            op_q, op_d;
  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                                  ovf_q, ovf_d;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  function automatic logic clamps(input logic signed [ACC_WIDTH-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  logic                          wr_en;
  int                            idx;
  logic [RW-1:0]                 row, col;
  logic signed [ACC_WIDTH-1:0]   acc, res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    idx     = 0;
    row     = '0;
    col     = '0;
    acc     = '0;
    res     = '0;

    case (state_q)
      S_RUN: begin
        if (abort_in) begin
          state_d = S_IDLE;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(BATCH_SIZE);
          if (int'(cnt_q) + BATCH_SIZE == NELEM) state_d = S_DONE;
        end
      end
      default: begin
        if (start_in) begin
          a_d     = tensor_core_input1;
          b_d     = tensor_core_input2;
          op_d    = operation_select_in;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // MAC reads c_q: element e is still its start value when its own batch is written.
    for (int j = 0; j < BATCH_SIZE; j++) begin
      idx = int'(cnt_q) + j;
      row = RW'(idx / DIM);
      col = RW'(idx % DIM);
      acc = '0;
      for (int k = 0; k < DIM; k++) begin
        acc = acc + sext(a_q[row][RW'(k)]) * sext(b_q[RW'(k)][col]);
      end
      case (op_q)
        OP_ADD:  res = sext(a_q[row][col]) + sext(b_q[row][col]);
        OP_RELU: res = a_q[row][col][DATA_WIDTH-1] ? '0 : sext(a_q[row][col]);
        OP_MAC:  res = sext(c_q[row][col]) + acc;
        default: res = acc;
      endcase
      if (wr_en) begin
        c_d[row][col] = saturate(res);
        ovf_d         = ovf_d | clamps(res);
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MATMUL;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tensor_core_output = c_q;
  assign busy_out           = (state_q == S_RUN);
  assign done_out           = (state_q == S_DONE);
  assign overflow_out       = ovf_q;

endmodule

// File: tb/tb_tensor_core_engine.sv
// Bench for tensor_core_engine: directed scenarios plus random operations against
// an integer matrix model, on three parameterisations.
module tb_tensor_core_engine;
  typedef int imat_t [8][8];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort_s = 1'b0;
  logic [1:0] op_s = 2'b00;
  logic start4 = 1'b0, start1 = 1'b0, start8 = 1'b0;
  logic [3:0][3:0][7:0] a4 = '0, b4 = '0, c4, c1;
  logic [7:0][7:0][7:0] a8 = '0, b8 = '0, c8;
  logic busy4, done4, ovf4, busy1, done1, ovf1, busy8, done8, ovf8;

  always #5 clk = ~clk;

  tensor_core_engine #(.DATA_WIDTH(8), .DIM(4), .BATCH_SIZE(4)) u_dut (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start4), .abort_in(abort_s),
    .operation_select_in(op_s), .tensor_core_input1(a4), .tensor_core_input2(b4),
    .tensor_core_output(c4), .busy_out(busy4), .done_out(done4), .overflow_out(ovf4));

  tensor_core_engine #(.DATA_WIDTH(8), .DIM(4), .BATCH_SIZE(1)) u_b1 (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start1), .abort_in(abort_s),
    .operation_select_in(op_s), .tensor_core_input1(a4), .tensor_core_input2(b4),
    .tensor_core_output(c1), .busy_out(busy1), .done_out(done1), .overflow_out(ovf1));

  tensor_core_engine #(.DATA_WIDTH(8), .DIM(8), .BATCH_SIZE(8)) u_d8 (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start8), .abort_in(abort_s),
    .operation_select_in(op_s), .tensor_core_input1(a8), .tensor_core_input2(b8),
    .tensor_core_output(c8), .busy_out(busy8), .done_out(done8), .overflow_out(ovf8));

  int total = 0;
  int bad = 0;
  imat_t ma, mb, mexp, mwant, mgot, mzero;
  bit ovf_want;

  function automatic void model(input int op, input int n, input imat_t a, input imat_t b,
                                input imat_t cp, output imat_t c, output bit ovf);
    ovf = 1'b0;
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) c[r][q] = 0;
    for (int r = 0; r < n; r++) begin
      for (int q = 0; q < n; q++) begin
        int v;
        v = 0;
        case (op)
          1: v = a[r][q] + b[r][q];
          2: v = (a[r][q] < 0) ? 0 : a[r][q];
          3: begin v = cp[r][q]; for (int k = 0; k < n; k++) v += a[r][k] * b[k][q]; end
          default: for (int k = 0; k < n; k++) v += a[r][k] * b[k][q];
        endcase
        if (v > 127) begin v = 127; ovf = 1'b1; end
        else if (v < -128) begin v = -128; ovf = 1'b1; end
        c[r][q] = v;
      end
    end
  endfunction

  function automatic int ndiff(input imat_t got, input imat_t want, input int n,
                               output int fr, output int fc);
    int cnt;
    cnt = 0; fr = 0; fc = 0;
    for (int r = n - 1; r >= 0; r--)
      for (int q = n - 1; q >= 0; q--)
        if (got[r][q] != want[r][q]) begin cnt++; fr = r; fc = q; end
    return cnt;
  endfunction

  function automatic void unpack4(input logic [3:0][3:0][7:0] p, output imat_t m);
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) m[r][q] = 0;
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) m[r][q] = {{24{p[r][q][7]}}, p[r][q]};
  endfunction

  function automatic void unpack8(input logic [7:0][7:0][7:0] p, output imat_t m);
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) m[r][q] = {{24{p[r][q][7]}}, p[r][q]};
  endfunction

  task automatic load4();
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin a4[r][q] = ma[r][q][7:0]; b4[r][q] = mb[r][q][7:0]; end
  endtask

  task automatic fill(input int av, input int bv);
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) begin ma[r][q] = av; mb[r][q] = bv; end
  endtask

  task automatic rand_ab();
    for (int r = 0; r < 8; r++)
      for (int q = 0; q < 8; q++) begin
        ma[r][q] = int'($urandom_range(0, 255)) - 128;
        mb[r][q] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  // Runs one operation on the 4x4 batch-4 engine and returns one cycle after done.
  task automatic run4(input int op, output int busy_n, output int done_n, output bit tmo);
    @(negedge clk); load4(); op_s = 2'(op); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    busy_n = 0; done_n = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin tmo = 1'b0; break; end
      if (busy4) busy_n++;
      @(negedge clk);
    end
    if (!tmo) begin done_n = 1; @(negedge clk); if (done4) done_n++; end
  endtask

  task automatic test_reset();
    #12;
    unpack4(c4, mgot);
    total++; if (ndiff(mgot, mzero, 4, ma[0][0], ma[0][1]) != 0) begin bad++; $display("FAIL reset_c4: output not zero, C[0][0]=%0d want 0", mgot[0][0]); end
    total++; if ({busy4, done4, ovf4} !== 3'b000) begin bad++; $display("FAIL reset_flags: busy/done/ovf=%b want 000", {busy4, done4, ovf4}); end
    total++; if ({busy1, done1, ovf1, busy8, done8, ovf8} !== 6'b0) begin bad++; $display("FAIL reset_other_flags: got %b want 000000", {busy1, done1, ovf1, busy8, done8, ovf8}); end
    total++; if (c1 !== '0 || c8 !== '0) begin bad++; $display("FAIL reset_other_c: c1=%h c8=%h want 0", c1, c8); end
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) mexp[r][q] = 0;
  endtask

  task automatic test_identity();
    int bn, dn, fr, fc, nd; bit tmo;
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) begin ma[r][q] = (r == q) ? 1 : 0; mb[r][q] = 4*r + q; end
    run4(0, bn, dn, tmo);
    model(0, 4, ma, mb, mexp, mwant, ovf_want); mexp = mwant;
    unpack4(c4, mgot);
    total++; if (tmo) begin bad++; $display("FAIL ident_timeout: no done within 40 cycles"); end
    total++; if (bn != 4) begin bad++; $display("FAIL ident_busy_len: busy %0d cycles want 4", bn); end
    total++; if (dn != 1) begin bad++; $display("FAIL ident_done_len: done %0d cycles want 1", dn); end
    nd = ndiff(mgot, mb, 4, fr, fc);
    total++; if (nd != 0) begin bad++; $display("FAIL ident_c: %0d wrong, C[%0d][%0d]=%0d want %0d", nd, fr, fc, mgot[fr][fc], mb[fr][fc]); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL ident_ovf: got %b want 0", ovf4); end
  endtask

  task automatic test_saturate();
    int bn, dn, fr, fc, nd; bit tmo;
    fill(100, 100);
    run4(0, bn, dn, tmo);
    unpack4(c4, mgot);
    fill(127, 127);
    nd = ndiff(mgot, ma, 4, fr, fc);
    total++; if (tmo || nd != 0) begin bad++; $display("FAIL sat_c: tmo=%0d %0d wrong, C[%0d][%0d]=%0d want 127", tmo, nd, fr, fc, mgot[fr][fc]); end
    total++; if (ovf4 !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b want 1", ovf4); end
    fill(0, 0);
    run4(0, bn, dn, tmo);
    unpack4(c4, mgot);
    nd = ndiff(mgot, mzero, 4, fr, fc);
    total++; if (tmo || nd != 0) begin bad++; $display("FAIL sat_zero_c: tmo=%0d C[%0d][%0d]=%0d want 0", tmo, fr, fc, mgot[fr][fc]); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL sat_ovf_clear: got %b want 0", ovf4); end
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) mexp[r][q] = 0;
  endtask

  task automatic test_add();
    int bn, dn, fr, fc, nd; bit tmo;
    int av[3] = '{100, -100, 5};
    int bv[3] = '{100, -100, -7};
    int cv[3] = '{127, -128, -2};
    logic ov[3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      fill(av[t], bv[t]);
      run4(1, bn, dn, tmo);
      unpack4(c4, mgot);
      fill(cv[t], cv[t]);
      nd = ndiff(mgot, ma, 4, fr, fc);
      total++; if (tmo || nd != 0) begin bad++; $display("FAIL add_c[%0d]: tmo=%0d C[%0d][%0d]=%0d want %0d", t, tmo, fr, fc, mgot[fr][fc], cv[t]); end
      total++; if (ovf4 !== ov[t]) begin bad++; $display("FAIL add_ovf[%0d]: got %b want %b", t, ovf4, ov[t]); end
    end
    mexp = ma;
  endtask

  task automatic test_relu();
    int bn, dn, fr, fc, nd; bit tmo;
    rand_ab();
    for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) ma[r][q] = (((r + q) % 2) == 0) ? (r + q + 1) : -(r + q + 1);
    run4(2, bn, dn, tmo);
    model(2, 4, ma, mb, mexp, mwant, ovf_want); mexp = mwant;
    unpack4(c4, mgot);
    nd = ndiff(mgot, mexp, 4, fr, fc);
    total++; if (tmo || nd != 0) begin bad++; $display("FAIL relu_c: tmo=%0d C[%0d][%0d]=%0d want %0d", tmo, fr, fc, mgot[fr][fc], mexp[fr][fc]); end
    total++; if (mgot[0][1] != 0 || mgot[1][1] != 3) begin bad++; $display("FAIL relu_spot: C[0][1]=%0d want 0, C[1][1]=%0d want 3", mgot[0][1], mgot[1][1]); end
  endtask

  task automatic test_mac();
    int bn, dn; bit tmo, seen;
    fill(0, 0);
    run4(0, bn, dn, tmo);
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) begin ma[r][q] = (r == q) ? 1 : 0; mb[r][q] = 3; end
    for (int t = 1; t <= 2; t++) begin
      run4(3, bn, dn, tmo);
      unpack4(c4, mgot);
      total++; if (tmo || mgot[1][2] != 3*t || mgot[3][0] != 3*t) begin bad++; $display("FAIL mac_%0d: C[1][2]=%0d C[3][0]=%0d want %0d", t, mgot[1][2], mgot[3][0], 3*t); end
    end
    @(negedge clk); load4(); op_s = 2'b11; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (done4) begin seen = 1'b1; break; end @(negedge clk); end
    unpack4(c4, mgot);
    total++; if (!seen || mgot[2][2] != 9) begin bad++; $display("FAIL mac_3: done=%0d C[2][2]=%0d want 9", seen, mgot[2][2]); end
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    total++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin bad++; $display("FAIL mac_b2b: busy=%b done=%b want 1/0", busy4, done4); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin if (done4) begin seen = 1'b1; break; end @(negedge clk); end
    unpack4(c4, mgot);
    total++; if (!seen || mgot[0][3] != 12 || mgot[3][3] != 12) begin bad++; $display("FAIL mac_4: done=%0d C[0][3]=%0d C[3][3]=%0d want 12", seen, mgot[0][3], mgot[3][3]); end
    @(negedge clk);
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) mexp[r][q] = (r < 4 && q < 4) ? 12 : 0;
  endtask

  task automatic test_random();
    int bn, dn, fr, fc, nd, op; bit tmo;
    for (int it = 0; it < 10; it++) begin
      op = int'($urandom_range(0, 3));
      rand_ab();
      if (it % 3 == 0) for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) begin ma[r][q] /= 8; mb[r][q] /= 8; end
      model(op, 4, ma, mb, mexp, mwant, ovf_want);
      run4(op, bn, dn, tmo);
      mexp = mwant;
      unpack4(c4, mgot);
      nd = ndiff(mgot, mexp, 4, fr, fc);
      total++; if (tmo || nd != 0) begin bad++; $display("FAIL rand_c[%0d] op=%0d: tmo=%0d C[%0d][%0d]=%0d want %0d", it, op, tmo, fr, fc, mgot[fr][fc], mexp[fr][fc]); end
      total++; if (ovf4 !== ovf_want) begin bad++; $display("FAIL rand_ovf[%0d] op=%0d: got %b want %b", it, op, ovf4, ovf_want); end
    end
  endtask

  task automatic test_control();
    int bn, fr, fc, nd; bit tmo, seen;
    rand_ab();
    model(0, 4, ma, mb, mexp, mwant, ovf_want);
    @(negedge clk); load4(); op_s = 2'b00; start4 = 1'b1;
    bn = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done4) begin tmo = 1'b0; break; end
      if (busy4) bn++;
      start4 = (i < 2);
      if (i < 3) begin a4 = {$urandom, $urandom, $urandom, $urandom}; b4 = {$urandom, $urandom, $urandom, $urandom}; op_s = 2'(i + 1); end
    end
    start4 = 1'b0;
    @(negedge clk);
    mexp = mwant;
    unpack4(c4, mgot);
    nd = ndiff(mgot, mexp, 4, fr, fc);
    total++; if (tmo || bn != 4) begin bad++; $display("FAIL ctl_hold_busy: tmo=%0d busy %0d cycles want 4", tmo, bn); end
    total++; if (nd != 0) begin bad++; $display("FAIL ctl_live_inputs: C[%0d][%0d]=%0d want %0d", fr, fc, mgot[fr][fc], mexp[fr][fc]); end

    fill(1, 2);
    model(1, 4, ma, mb, mexp, mwant, ovf_want);
    for (int q = 0; q < 4; q++) mexp[0][q] = mwant[0][q];
    @(negedge clk); load4(); op_s = 2'b01; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); abort_s = 1'b1; start4 = 1'b1;
    @(negedge clk); abort_s = 1'b0; start4 = 1'b0;
    total++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin bad++; $display("FAIL ctl_abort_flags: busy=%b done=%b want 0/0", busy4, done4); end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin if (done4 || busy4) seen = 1'b1; @(negedge clk); end
    total++; if (seen) begin bad++; $display("FAIL ctl_abort_done: busy/done seen after abort, want none"); end
    unpack4(c4, mgot);
    nd = ndiff(mgot, mexp, 4, fr, fc);
    total++; if (nd != 0 || mgot[0][0] != 3) begin bad++; $display("FAIL ctl_abort_c: C[%0d][%0d]=%0d want %0d (C[0][0]=%0d want 3)", fr, fc, mgot[fr][fc], mexp[fr][fc], mgot[0][0]); end

    rand_ab();
    @(negedge clk); load4(); op_s = 2'b00; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++; if (c4 !== '0 || busy4 !== 1'b0 || ovf4 !== 1'b0) begin bad++; $display("FAIL ctl_async_reset: c4=%h busy=%b ovf=%b want 0", c4, busy4, ovf4); end
    @(negedge clk); rst_n = 1'b1;
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) mexp[r][q] = 0;
  endtask

  task automatic test_batch1();
    int bn, fr, fc, nd; bit tmo;
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) begin ma[r][q] = (r == q) ? 1 : 0; mb[r][q] = 4*r + q; end
    @(negedge clk); load4(); op_s = 2'b00; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    bn = 0; tmo = 1'b1;
    for (int i = 0; i < 60; i++) begin if (done1) begin tmo = 1'b0; break; end if (busy1) bn++; @(negedge clk); end
    unpack4(c1, mgot);
    nd = ndiff(mgot, mb, 4, fr, fc);
    total++; if (tmo || bn != 16) begin bad++; $display("FAIL b1_busy_len: tmo=%0d busy %0d cycles want 16", tmo, bn); end
    total++; if (nd != 0 || ovf1 !== 1'b0) begin bad++; $display("FAIL b1_c: C[%0d][%0d]=%0d want %0d ovf=%b", fr, fc, mgot[fr][fc], mb[fr][fc], ovf1); end
    @(negedge clk);
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL b1_done_len: done still %b want 0", done1); end
  endtask

  task automatic test_dim8();
    int bn, fr, fc, nd; bit tmo;
    for (int r = 0; r < 8; r++)
      for (int q = 0; q < 8; q++) begin
        ma[r][q] = (r == q) ? 1 : 0; mb[r][q] = 8*r + q;
        a8[r][q] = ma[r][q][7:0]; b8[r][q] = mb[r][q][7:0];
      end
    @(negedge clk); op_s = 2'b00; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    bn = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin if (done8) begin tmo = 1'b0; break; end if (busy8) bn++; @(negedge clk); end
    unpack8(c8, mgot);
    nd = ndiff(mgot, mb, 8, fr, fc);
    total++; if (tmo || bn != 8) begin bad++; $display("FAIL d8_busy_len: tmo=%0d busy %0d cycles want 8", tmo, bn); end
    total++; if (nd != 0 || ovf8 !== 1'b0) begin bad++; $display("FAIL d8_c: C[%0d][%0d]=%0d want %0d ovf=%b", fr, fc, mgot[fr][fc], mb[fr][fc], ovf8); end
    @(negedge clk);
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL d8_done_len: done still %b want 0", done8); end
  endtask

  initial begin
    for (int r = 0; r < 8; r++) for (int q = 0; q < 8; q++) mzero[r][q] = 0;
    test_reset();
    test_identity();
    test_saturate();
    test_add();
    test_relu();
    test_mac();
    test_random();
    test_control();
    test_batch1();
    test_dim8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_core_engine.md
Name: tensor_core_engine

Overview:
- Parametrised successor of the 4x4 small tensor core: a DIMxDIM signed matrix engine computing BATCH_SIZE output elements per clock.
- Operations: matmul, matmul-accumulate, element-wise add and ReLU, with saturating arithmetic.
- Operands are captured at start; an explicit start/busy/done handshake, abort and overflow flag are provided.
- Sits between the tensor register file and the writeback path; the register file may be rewritten while the engine runs.

Parameters:
- DATA_WIDTH, 8, signed element width.
- DIM, 4, matrix dimension (DIMxDIM operands and result).
- BATCH_SIZE, 4, output elements computed per RUN cycle. Must divide DIM*DIM (elaboration error otherwise).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(DIM)+1, internal dot-product / accumulator width.

Ports:
- clock_in  input  1  clock; all state on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request operation; accepted only in IDLE or DONE.
- abort_in  input  1  synchronous abort of a running operation.
- operation_select_in  input  2  00 matmul, 01 add, 10 relu, 11 matmul-accumulate.
- tensor_core_input1  input  [DIM][DIM] x DATA_WIDTH signed  operand A.
- tensor_core_input2  input  [DIM][DIM] x DATA_WIDTH signed  operand B.
- tensor_core_output  output  [DIM][DIM] x DATA_WIDTH signed  registered result C.
- busy_out  output  1  high in RUN.
- done_out  output  1  one-cycle pulse after the final batch is written.
- overflow_out  output  1  sticky; set if any element saturated since the last accepted start.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, counter=0, captured operands=0, tensor_core_output all 0.
  - busy_out=0, done_out=0, overflow_out=0.
- States: IDLE, RUN, DONE.
- Start acceptance: if start_in=1 at an edge while state is IDLE or DONE:
  - A and B are latched into internal copies; operation_select_in is latched.
  - counter=0, overflow_out cleared, state goes to RUN.
  - start_in in RUN is ignored.
- RUN, each edge:
  - Elements e = counter .. counter+BATCH_SIZE-1 (row-major: row=e/DIM, col=e%DIM) are written to tensor_core_output.
  - counter += BATCH_SIZE.
  - When counter+BATCH_SIZE == DIM*DIM, go to DONE.
  - RUN lasts exactly K = DIM*DIM/BATCH_SIZE cycles.
- Latency:
  - Start sampled at edge t0; batches are written at edges t1..tK.
  - busy_out is high from t0 to tK; done_out is high from tK to tK+1.
  - DONE returns to IDLE at the next edge unless a new start is accepted there (back-to-back operations allowed, no bubble beyond DONE).
- Element functions (computed at ACC_WIDTH from captured operands):
  - matmul: sum over k of A[r][k]*B[k][c].
  - add: A[r][c]+B[r][c].
  - relu: A[r][c] if A[r][c] >= 0, else 0.
  - matmul-accumulate: C_prev[r][c] + sum over k of A[r][k]*B[k][c], where C_prev is the output register value at start.
- Saturation: each result is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets overflow_out at the same edge the element is written.
- Output hold:
  - Elements not yet written hold their previous values.
  - Outputs hold indefinitely in IDLE/DONE.
  - Live changes on the input ports during RUN have no effect.
- Abort: abort_in=1 in RUN sends the engine to IDLE at that edge.
  - No batch is written at that edge; busy_out drops and done_out stays 0.
  - Already-written elements are kept.
  - abort_in has priority over start_in; it is ignored outside RUN.
- Reset asserted mid-RUN: immediate return to the reset state, including outputs cleared.

Test Plan:
1. DIM=4, BATCH=4, A=identity, B[r][c]=4r+c, start matmul at t0:
   - busy high at t1..t4; C==B after t4.
   - done pulses exactly one cycle; overflow=0.
2. All elements 100, matmul:
   - Every C element = 127 (40000 saturates); overflow=1.
   - Next start with A=B=0 clears overflow, result all 0.
3. add with A=all 100, B=all 100 gives all 127. A=all -100, B=all -100 gives all -128. A=5, B=-7 gives -2, overflow=0.
4. relu with A[r][c] = (-1)^(r+c)*(r+c+1): negatives become 0, positives pass; B is ignored.
5. matmul-accumulate twice, A=identity, B=all 3: first C=3 (C_prev=0), second C=6. Third and fourth back-to-back starts gave 9 and 12 with no idle bubble.
6. Control edge cases:
   - start_in held during RUN: no restart, result unaffected.
   - Changing input ports mid-RUN: result unaffected.
   - abort at t2: rows 0 only written, rows 1..3 hold old values, done never pulses.
   - reset_n_in low mid-RUN: outputs 0 asynchronously.
   - Repeat scenario 1 with BATCH_SIZE=1 (16 RUN cycles) and DIM=8, BATCH_SIZE=8.
